// File: rtl/logic_req_sched.sv
// Two-requester round-robin front end for a shared bitwise logic unit.
// One operation in flight: IDLE grants, EXEC computes, RESP holds the tagged result.

module logic_top (
    input  logic signed [4:0] in1,
    input  logic signed [4:0] in2,
    input  logic        [2:0] opcode,
    output logic signed [8:0] out_logic
);
    logic [4:0] r;
    logic       unused_op;

    // Only opcode[1:0] selects the function; bit 2 is a don't-care.
    assign unused_op = opcode[2];

    always_comb begin
        r = '0;
        case (opcode[1:0])
            2'b00:   r = in1 | in2;
            2'b01:   r = in1 & in2;
            2'b10:   r = ~(in1 & in2);
            default: r = ~(in1 | in2);
        endcase
        out_logic = {{4{r[4]}}, r};
    end
endmodule

module logic_req_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [4:0]       a_in1,
    input  logic [4:0]       a_in2,
    input  logic [2:0]       a_opcode,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [4:0]       b_in1,
    input  logic [4:0]       b_in2,
    input  logic [2:0]       b_opcode,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [8:0]       rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // Requesters hold valid/payload until ready; the response holds until rsp_ready.

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [4:0]       in1_q, in1_d, in2_q, in2_d;
    logic [2:0]       op_q, op_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [8:0]       rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       out_logic;
    logic             grant_a, grant_b;

    logic_top u_logic (
        .in1       (in1_q),
        .in2       (in2_q),
        .opcode    (op_q),
        .out_logic (out_logic)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        cnt_d       = cnt_q;
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        case (state_q)
            IDLE: begin
                // ptr_q = 0 favours A on a tie, 1 favours B.
                grant_a = a_valid && (!b_valid || !ptr_q);
                grant_b = b_valid && (!a_valid || ptr_q);
                if (grant_a) begin
                    in1_d   = a_in1;
                    in2_d   = a_in2;
                    op_d    = a_opcode;
                    id_d    = 1'b0;
                    ptr_d   = 1'b1;
                    state_d = EXEC;
                end else if (grant_b) begin
                    in1_d   = b_in1;
                    in2_d   = b_in2;
                    op_d    = b_opcode;
                    id_d    = 1'b1;
                    ptr_d   = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = out_logic;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            in1_q       <= '0;
            in2_q       <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);
    assign op_count  = cnt_q;
endmodule

// File: tb/tb_logic_req_sched.sv
// Bench for logic_req_sched: transaction-level model with an expected-result queue,
// directed opcode/fairness/stall/reset cases, then randomized traffic.

module tb_logic_req_sched;
    localparam int CNT_W = 8;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic             a_valid, b_valid, rsp_ready;
    logic             a_ready, b_ready, rsp_valid, rsp_id, busy;
    logic [4:0]       a_in1, a_in2, b_in1, b_in2;
    logic [2:0]       a_opcode, b_opcode;
    logic [8:0]       rsp_data;
    logic [CNT_W-1:0] op_count;

    always #5 clk = ~clk;

    logic_req_sched #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_in1     (a_in1),
        .a_in2     (a_in2),
        .a_opcode  (a_opcode),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_in1     (b_in1),
        .b_in2     (b_in2),
        .b_opcode  (b_opcode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    // ---------------- scoreboard state ----------------
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               total_done = 0;
    logic [9:0]       exp_q[$];          // {id, data} of accepted operations
    int               acc_cyc[$];
    int               acc_id[$];
    bit               m_known = 1'b0;
    bit               m_busy = 1'b0;
    bit               m_ptr = 1'b0;      // 0: A wins a tie
    int               m_age = 0;         // edges since accept while busy
    logic [CNT_W-1:0] m_cnt = '0;
    logic [8:0]       last_data = '0;
    logic             last_id = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference function: bitwise op on 5 bits, then value reinterpreted as signed.
    function automatic logic [8:0] ref_op(input logic [4:0] x, input logic [4:0] y,
                                          input logic [2:0] op);
        logic [4:0] r;
        int         v;
        case (op % 4)
            0:       r = x | y;
            1:       r = x & y;
            2:       r = ~(x & y);
            default: r = ~(x | y);
        endcase
        v = (r >= 16) ? int'(r) - 32 : int'(r);
        return v[8:0];
    endfunction

    // ---------------- driver / model step ----------------
    // Called at a falling edge with inputs set; checks, advances one rising edge.
    task automatic step();
        bit ea, eb, rv;
        #1;
        ea = !m_busy && a_valid && (!b_valid || !m_ptr);
        eb = !m_busy && b_valid && (!a_valid || m_ptr);
        rv = m_busy && (m_age >= 1);
        if (m_known) begin
            check("a_ready", a_ready, ea);
            check("b_ready", b_ready, eb);
            check("busy", busy, m_busy);
            check("rsp_valid", rsp_valid, rv);
            check("op_count", op_count, m_cnt);
            if (rv && exp_q.size() > 0) begin
                check("rsp_id", rsp_id, exp_q[0][9]);
                check("rsp_data", rsp_data, exp_q[0][8:0]);
            end
        end
        if (!rst_n) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_ptr   = 1'b0;
            m_age   = 0;
            m_cnt   = '0;
            exp_q.delete();
            ea = 1'b0;
            eb = 1'b0;
        end else if (m_known) begin
            if (m_busy) begin
                if (rv && rsp_ready) begin
                    last_data = rsp_data;
                    last_id   = rsp_id;
                    void'(exp_q.pop_front());
                    m_busy = 1'b0;
                    m_cnt++;
                    total_done++;
                end else begin
                    m_age = 1;
                end
            end else if (ea) begin
                exp_q.push_back({1'b0, ref_op(a_in1, a_in2, a_opcode)});
                m_busy = 1'b1; m_age = 0; m_ptr = 1'b1;
                acc_cyc.push_back(cyc); acc_id.push_back(0);
            end else if (eb) begin
                exp_q.push_back({1'b1, ref_op(b_in1, b_in2, b_opcode)});
                m_busy = 1'b1; m_age = 0; m_ptr = 1'b0;
                acc_cyc.push_back(cyc); acc_id.push_back(1);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (ea) a_valid = 1'b0;
        if (eb) b_valid = 1'b0;
    endtask

    task automatic gen(input int pa, input int pb, input int pr);
        if (!a_valid && $urandom_range(0, 99) < pa) begin
            a_valid  = 1'b1;
            a_in1    = 5'($urandom_range(0, 31));
            a_in2    = 5'($urandom_range(0, 31));
            a_opcode = 3'($urandom_range(0, 7));
        end
        if (!b_valid && $urandom_range(0, 99) < pb) begin
            b_valid  = 1'b1;
            b_in1    = 5'($urandom_range(0, 31));
            b_in2    = 5'($urandom_range(0, 31));
            b_opcode = 3'($urandom_range(0, 7));
        end
        rsp_ready = ($urandom_range(0, 99) < pr);
    endtask

    task automatic run_one(input bit id, input logic [4:0] x, input logic [4:0] y,
                           input logic [2:0] op, input logic [8:0] exp_data);
        int start;
        start = total_done;
        a_valid = !id; b_valid = id; rsp_ready = 1'b1;
        a_in1 = x; a_in2 = y; a_opcode = op;
        b_in1 = x; b_in2 = y; b_opcode = op;
        for (int i = 0; i < 20 && total_done == start; i++) step();
        check("one_done", total_done, start + 1);
        check("one_data", last_data, exp_data);
        check("one_id", last_id, id);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [2:0] ops[5];
        logic [8:0] res[5];
        int         start;
        ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
        res = '{9'h00E, 9'h008, 9'h1F7, 9'h1F1, 9'h1F1};
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b0;
        a_in1 = '0; a_in2 = '0; a_opcode = '0; b_in1 = '0; b_in2 = '0; b_opcode = '0;
        @(negedge clk);
        step();
        step();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        rst_n = 1'b1;

        // Opcode sweep on A, and one through B
        for (int i = 0; i < 5; i++) run_one(1'b0, 5'b01100, 5'b01010, ops[i], res[i]);
        run_one(1'b1, 5'b01100, 5'b01010, 3'b010, 9'h1F7);
        check("sweep_count", op_count, 6);

        // Response back-pressure for 5 RESP cycles while B is also requesting
        start = total_done;
        a_valid = 1'b1; a_in1 = 5'b10011; a_in2 = 5'b00101; a_opcode = 3'b001;
        b_valid = 1'b0; rsp_ready = 1'b0;
        step();
        b_valid = 1'b1; b_in1 = 5'b00001; b_in2 = 5'b00010; b_opcode = 3'b000;
        for (int i = 0; i < 6; i++) step();
        check("stall_rsp_valid", rsp_valid, 1);
        check("stall_busy", busy, 1);
        rsp_ready = 1'b1;
        step();
        check("stall_done", total_done, start + 1);
        check("stall_data", last_data, 9'h001);

        // Fairness from reset with both requesters always valid
        rst_n = 1'b0; step(); rst_n = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        acc_cyc.delete(); acc_id.delete();
        for (int i = 0; i < 12; i++) begin
            gen(100, 100, 100);
            step();
        end
        check("fair_accepts", acc_id.size(), 4);
        for (int i = 0; i < acc_id.size() && i < 4; i++) check("fair_id", acc_id[i], i % 2);
        for (int i = 1; i < acc_cyc.size() && i < 4; i++)
            check("fair_gap", acc_cyc[i] - acc_cyc[i-1], 3);
        check("fair_count", op_count, 4);

        // Reset while in EXEC drops the operation and re-points to A
        a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        a_valid = 1'b1; a_in1 = 5'b00111; a_in2 = 5'b00001; a_opcode = 3'b000;
        step();
        check("exec_busy", busy, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("exec_rst_valid", rsp_valid, 0);
        check("exec_rst_busy", busy, 0);
        check("exec_rst_count", op_count, 0);
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        check("exec_rst_grant_a", a_ready, 1);
        check("exec_rst_grant_b", b_ready, 0);
        step();

        // Random traffic; op_count wraps several times at CNT_W bits
        for (int i = 0; i < 2500; i++) begin
            gen(60, 70, 65);
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("drain_empty", exp_q.size(), 0);
        check("wrapped", (total_done > (1 << CNT_W)), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
